dm_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate cache between the Riscv151 core's `icache_*`/`dcache_*` port pair and main memory; one instance serves each port. It gives hits with the core's one-cycle synchronous-read timing and asserts `stall` on misses and writes. It issues line refills and word writes over a valid/ready memory request channel and accepts refill data over a valid-only response channel.

---
 rtl/cache_pkg.sv | 28 ++
 rtl/cache_data_array.sv | 31 +++
 rtl/dm_cache.sv | 136 +++++++++++++
 tb/tb_dm_cache.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding, memory request codes and address-field width helpers for dm_cache.
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_REFILL_REQ,
        S_REFILL_WAIT,
        S_RESPOND
    } state_t;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int word_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Byte offset is always 2 bits; the tag takes whatever remains of the 32-bit address.
    function automatic int tag_w(input int lines, input int line_words);
        return 30 - idx_w(lines) - word_w(line_words);
    endfunction

endpackage

// File: rtl/cache_data_array.sv
// cache_data_array: LINES x LINE_WORDS x 32-bit storage, synchronous read, per-byte write enables.
// Ports: clk; i_rd_en/i_rd_idx/i_rd_word -> o_rd_data (registered);
//        i_wr_idx/i_wr_word/i_wr_be/i_wr_data write one word under a byte mask.
module cache_data_array
    import cache_pkg::*;
#(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                            clk,
    input  logic                            i_rd_en,
    input  logic [idx_w(LINES)-1:0]         i_rd_idx,
    input  logic [word_w(LINE_WORDS)-1:0]   i_rd_word,
    output logic [31:0]                     o_rd_data,
    input  logic [idx_w(LINES)-1:0]         i_wr_idx,
    input  logic [word_w(LINE_WORDS)-1:0]   i_wr_word,
    input  logic [3:0]                      i_wr_be,
    input  logic [31:0]                     i_wr_data
);

    logic [31:0] r_mem [LINES*LINE_WORDS];

    always_ff @(posedge clk) begin
        if (i_rd_en)
            o_rd_data <= r_mem[{i_rd_idx, i_rd_word}];
        for (int b = 0; b < 4; b++)
            if (i_wr_be[b])
                r_mem[{i_wr_idx, i_wr_word}][8*b +: 8] <= i_wr_data[8*b +: 8];
    end

endmodule

// File: rtl/dm_cache.sv
// dm_cache: direct-mapped, write-through, no-write-allocate cache with one-cycle read hits.
// Ports: clk, reset (sync, active-low);
//        cpu_addr/cpu_re/cpu_we/cpu_din in, cpu_dout/stall out (core side);
//        mem_req_valid/ready/rw/addr/data/mask request channel, mem_resp_valid/data refill beats.
module dm_cache
    import cache_pkg::*;
#(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_re,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_din,
    output logic [31:0] cpu_dout,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_rw,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic [3:0]  mem_req_mask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int IW = idx_w(LINES);
    localparam int WW = word_w(LINE_WORDS);
    localparam int TW = tag_w(LINES, LINE_WORDS);
    localparam int IL = 2 + WW;
    localparam int TL = 2 + WW + IW;

    state_t          r_state, w_next;
    logic            r_req, r_wr;
    logic [TW-1:0]   r_tag;
    logic [IW-1:0]   r_idx;
    logic [WW-1:0]   r_word, r_cnt;
    logic [31:0]     r_din, r_dout;
    logic [3:0]      r_mask;
    logic [LINES-1:0] r_valid;
    logic [TW-1:0]   r_tags [LINES];

    logic            w_hit, w_hs, w_last, w_beat;
    logic [31:0]     w_rdata;
    logic [3:0]      w_be;
    logic            w_unused;

    assign w_unused = &{1'b0, cpu_addr[1:0]};

    // Tags do not change while a request is outstanding, so this compare is valid in every state.
    assign w_hit  = r_valid[r_idx] && r_tags[r_idx] == r_tag;
    assign w_hs   = mem_req_valid && mem_req_ready;
    assign w_beat = r_state == S_REFILL_WAIT && mem_resp_valid;
    assign w_last = w_beat && r_cnt == WW'(LINE_WORDS - 1);

    assign stall = (r_state == S_IDLE) ? (r_req && (r_wr || !w_hit))
                 : (r_state == S_WRITE || r_state == S_REFILL_REQ || r_state == S_REFILL_WAIT);

    assign cpu_dout = (r_state == S_RESPOND) ? r_dout
                    : (r_state == S_IDLE && r_req && !r_wr) ? w_rdata : '0;

    assign mem_req_valid = r_state == S_WRITE || r_state == S_REFILL_REQ;
    assign mem_req_rw    = (r_state == S_WRITE) ? MEM_WR : MEM_RD;
    assign mem_req_addr  = (r_state == S_WRITE) ? {r_tag, r_idx, r_word, 2'b00}
                         : (r_state == S_REFILL_REQ) ? {r_tag, r_idx, {(WW+2){1'b0}}} : '0;
    assign mem_req_data  = (r_state == S_WRITE) ? r_din : '0;
    assign mem_req_mask  = (r_state == S_WRITE) ? r_mask : '0;

    // Write hits update only the masked bytes; refill beats write whole words.
    assign w_be = (r_state == S_WRITE && w_hit) ? r_mask : w_beat ? 4'hF : 4'h0;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:        w_next = !r_req ? S_IDLE : r_wr ? S_WRITE : w_hit ? S_IDLE : S_REFILL_REQ;
            S_WRITE:       w_next = w_hs ? S_RESPOND : S_WRITE;
            S_REFILL_REQ:  w_next = w_hs ? S_REFILL_WAIT : S_REFILL_REQ;
            S_REFILL_WAIT: w_next = w_last ? S_RESPOND : S_REFILL_WAIT;
            S_RESPOND:     w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_valid <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
        end else begin
            r_state <= w_next;
            if (!stall) begin
                r_req  <= cpu_re || |cpu_we;
                r_wr   <= |cpu_we;
                r_tag  <= cpu_addr[31:TL];
                r_idx  <= cpu_addr[TL-1:IL];
                r_word <= cpu_addr[IL-1:2];
                r_din  <= cpu_din;
                r_mask <= cpu_we;
            end
            if (r_state == S_REFILL_REQ && w_hs)
                r_cnt <= '0;
            if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == r_word)
                    r_dout <= mem_resp_data;
            end
            if (w_last) begin
                r_valid[r_idx] <= 1'b1;
                r_tags[r_idx]  <= r_tag;
            end
            if (r_state == S_WRITE)
                r_dout <= '0;
        end
    end

    cache_data_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_data (
        .clk       (clk),
        .i_rd_en   (!stall),
        .i_rd_idx  (cpu_addr[TL-1:IL]),
        .i_rd_word (cpu_addr[IL-1:2]),
        .o_rd_data (w_rdata),
        .i_wr_idx  (r_idx),
        .i_wr_word ((r_state == S_WRITE) ? r_word : r_cnt),
        .i_wr_be   (w_be),
        .i_wr_data ((r_state == S_WRITE) ? r_din : mem_resp_data)
    );

endmodule

// File: tb/tb_dm_cache.sv
// tb_dm_cache: randomized and directed checks of dm_cache against a word-level memory and hit/miss model.
module tb_dm_cache;

    localparam int LW    = 4;
    localparam int NLINE = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_re = 1'b0;
    logic [3:0]  cpu_we = '0;
    logic [31:0] cpu_din = '0;
    logic [31:0] cpu_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_rw;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_mask;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem_m [logic [31:0]];
    bit          cv [NLINE];
    int unsigned ct [NLINE];
    logic [31:0] last_dout;
    int          last_nreq;
    int          bp_force = -1;

    dm_cache #(.LINES(NLINE), .LINE_WORDS(LW)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_re         (cpu_re),
        .cpu_we         (cpu_we),
        .cpu_din        (cpu_din),
        .cpu_dout       (cpu_dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_mask   (mem_req_mask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem_m.exists(a >> 2) ? mem_m[a >> 2] : ((a & ~32'h3) ^ 32'h5EED_0000);
    endfunction

    task automatic wr_mem(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] v;
        v = rd_mem(a);
        for (int b = 0; b < 4; b++)
            if (m[b]) v[8*b +: 8] = d[8*b +: 8];
        mem_m[a >> 2] = v;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NLINE; i++) cv[i] = 1'b0;
    endtask

    // One core access, acting as the memory while the cache stalls; inputs are changed 1 time unit after an edge.
    task automatic do_op(input logic [31:0] a, input logic re, input logic [3:0] we, input logic [31:0] d);
        bit          wr, hit, seen, beats_on;
        int          idx, cyc, nreq, beat, wt;
        logic [31:0] line, eaddr;
        logic [68:0] q;
        wr    = |we;
        idx   = int'((a >> 4) % NLINE);
        hit   = !wr && cv[idx] && ct[idx] == (a >> 10);
        line  = a & ~32'hF;
        eaddr = wr ? (a & ~32'h3) : line;
        cpu_addr = a; cpu_re = re; cpu_we = we; cpu_din = d;
        @(posedge clk); #1;
        chk("stall_after_capture", stall, !hit);
        cyc = 0; nreq = 0; seen = 0; beats_on = 0; beat = 0; wt = 0; q = '0;
        while (stall && cyc < 200) begin
            mem_req_ready = 1'b0;
            mem_resp_valid = 1'b0;
            if (beats_on && beat < LW && $urandom_range(2) != 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = rd_mem(line + 32'(4 * beat));
                beat++;
            end
            if (mem_req_valid) begin
                if (!seen) begin
                    seen = 1; nreq++;
                    chk("req_rw", mem_req_rw, wr);
                    chk("req_addr", mem_req_addr, eaddr);
                    if (wr) begin
                        chk("req_data", mem_req_data, d);
                        chk("req_mask", mem_req_mask, we);
                    end
                    wt = (bp_force >= 0) ? bp_force : int'($urandom_range(2));
                    q = {mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask};
                end else begin
                    chk("req_stable", {28'h0, q[3:0]} ^ {28'h0, mem_req_mask}, 32'h0);
                    chk("req_stable_addr", mem_req_addr, q[67:36]);
                    chk("req_stable_data", mem_req_data, q[35:4]);
                    chk("req_stable_rw", mem_req_rw, q[68]);
                end
                if (wt == 0) begin
                    mem_req_ready = 1'b1;
                    seen = 0;
                    if (wr) wr_mem(a, d, we); else beats_on = 1;
                end else wt--;
            end
            @(posedge clk); #1;
            cyc++;
        end
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        if (cyc >= 200) chk("timeout", 32'd1, 32'd0);
        chk("dout", cpu_dout, wr ? 32'h0 : rd_mem(a));
        chk("nreq", nreq, (wr || !hit) ? 32'd1 : 32'd0);
        chk("resp_no_req", mem_req_valid, 1'b0);
        if (!wr && !hit) begin cv[idx] = 1'b1; ct[idx] = a >> 10; end
        last_dout = cpu_dout;
        last_nreq = nreq;
        cpu_re = 1'b0; cpu_we = 4'h0;
    endtask

    task automatic reset_mid_refill(input logic [31:0] a);
        int cyc;
        cpu_addr = a; cpu_re = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (!mem_req_valid && cyc < 10) begin @(posedge clk); #1; cyc++; end
        chk("rst_req_seen", mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = rd_mem((a & ~32'hF) + 32'(4 * i));
            @(posedge clk); #1;
        end
        mem_resp_valid = 1'b0;
        cpu_re = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        clear_model();
        chk("rst_stall", stall, 1'b0);
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_dout", cpu_dout, 32'h0);
        for (int i = 2; i < LW; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hDEAD_0000 + 32'(i);
            @(posedge clk); #1;
            chk("late_beat_stall", stall, 1'b0);
            chk("late_beat_req", mem_req_valid, 1'b0);
        end
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  we;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall", stall, 1'b0);
        chk("reset_req_valid", mem_req_valid, 1'b0);
        chk("reset_dout", cpu_dout, 32'h0);
        chk("reset_req_addr", mem_req_addr, 32'h0);
        chk("reset_req_mask", {28'h0, mem_req_mask}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < LW; i++) mem_m[(32'h1000_0000 >> 2) + 32'(i)] = 32'hA0 + 32'(i);
        do_op(32'h1000_0004, 1'b1, 4'h0, 32'h0);
        chk("cold_miss_word1", last_dout, 32'hA1);
        do_op(32'h1000_0008, 1'b1, 4'h0, 32'h0);
        chk("hit_word2", last_dout, 32'hA2);
        chk("hit_no_request", last_nreq, 32'd0);

        do_op(32'h1000_0008, 1'b0, 4'b0011, 32'h1234_5678);
        do_op(32'h1000_0008, 1'b1, 4'h0, 32'h0);
        chk("write_hit_merge", last_dout, 32'h0000_5678);
        chk("write_hit_then_hit", last_nreq, 32'd0);

        do_op(32'h2000_0000, 1'b0, 4'hF, 32'hCAFE_F00D);
        do_op(32'h2000_0000, 1'b1, 4'h0, 32'h0);
        chk("write_miss_no_alloc", last_nreq, 32'd1);
        chk("write_miss_data", last_dout, 32'hCAFE_F00D);

        do_op(32'h1000_0000, 1'b1, 4'h0, 32'h0);
        do_op(32'h1000_0400, 1'b1, 4'h0, 32'h0);
        chk("conflict_miss", last_nreq, 32'd1);
        do_op(32'h1000_0000, 1'b1, 4'h0, 32'h0);
        chk("conflict_remiss", last_nreq, 32'd1);

        bp_force = 5;
        do_op(32'h1000_0810, 1'b1, 4'h0, 32'h0);
        do_op(32'h1000_0814, 1'b1, 4'b0101, 32'h5555_AAAA);
        bp_force = -1;

        reset_mid_refill(32'h3000_0020);
        do_op(32'h3000_0020, 1'b1, 4'h0, 32'h0);
        chk("reread_after_reset_miss", last_nreq, 32'd1);

        for (int n = 0; n < 200; n++) begin
            a = {$urandom_range(2) == 0 ? 22'h04_0000 : $urandom_range(1) == 0 ? 22'h04_0001 : 22'h08_0002,
                 6'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3))};
            if ($urandom_range(9) < 6) do_op(a, 1'b1, 4'h0, 32'h0);
            else begin
                we = 4'($urandom_range(14) + 1);
                do_op(a, 1'($urandom_range(1)), we, $urandom);
            end
            if ($urandom_range(4) == 0) begin
                @(posedge clk); #1;
                chk("idle_no_stall", stall, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
